// File: rtl/dragonfang_pkg.sv
// Shared types for the dragonfang vector execution stage: decoded multiply op, element width
// and the per-op operand signedness helpers.
package dragonfang_pkg;

  localparam int unsigned VlenBits = 64;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'd0,
    MUL_OP_MULH   = 2'd1,
    MUL_OP_MULHU  = 2'd2,
    MUL_OP_MULHSU = 2'd3
  } mul_op_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef struct packed {
    logic [4:0] vd_addr;
    logic       vm;
    mul_op_t    mul_op;
    sew_t       sew;
  } execution_vector_t;

  // vs2 is treated as signed for everything except vmulhu.
  function automatic logic op_vs2_signed(mul_op_t op);
    return op != MUL_OP_MULHU;
  endfunction

  function automatic logic op_vs1_signed(mul_op_t op);
    return (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  endfunction

endpackage

// File: rtl/vmul_lane.sv
// One W x W element multiplier; each operand is sign- or zero-extended to 2W by its flag and
// the 2W product is returned (wraps modulo 2^(2W)).
module vmul_lane #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           a_signed_i,
  input  logic           b_signed_i,
  output logic [2*W-1:0] prod_o
);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;

  assign a_ext  = {{W{a_signed_i & a_i[W-1]}}, a_i};
  assign b_ext  = {{W{b_signed_i & b_i[W-1]}}, b_i};
  assign prod_o = a_ext * b_ext;

endmodule

// File: rtl/vector_multiply_unit.sv
// 64-bit SIMD integer multiplier (vmul/vmulh/vmulhu/vmulhsu, SEW 8..64), registered output.
// Define VMUL_INPUT_REG_EN to add an input register stage (latency 2 instead of 1).
module vector_multiply_unit
  import dragonfang_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  execution_vector_t     execution_vector,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] vs2,
  input  logic [DATA_WIDTH-1:0] vs1,
  output logic [DATA_WIDTH-1:0] vd,
  output logic [DATA_WIDTH-1:0] vd_high,
  output logic                  valid_out
);

  execution_vector_t     ev;
  logic                  vld;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

`ifdef VMUL_INPUT_REG_EN
  execution_vector_t     ev_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] op_a_q;
  logic [DATA_WIDTH-1:0] op_b_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ev_q   <= '0;
      vld_q  <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
    end else begin
      ev_q   <= execution_vector;
      vld_q  <= valid_in;
      op_a_q <= vs2;
      op_b_q <= vs1;
    end
  end

  assign ev   = ev_q;
  assign vld  = vld_q;
  assign op_a = op_a_q;
  assign op_b = op_b_q;
`else
  assign ev   = execution_vector;
  assign vld  = valid_in;
  assign op_a = vs2;
  assign op_b = vs1;
`endif

  logic unused_ev_fields;
  assign unused_ev_fields = ^{ev.vd_addr, ev.vm};

  logic a_signed;
  logic b_signed;
  assign a_signed = op_vs2_signed(ev.mul_op);
  assign b_signed = op_vs1_signed(ev.mul_op);

  // Every SEW gets its own lane array; index k holds SEW = 8 << k, low and high product halves.
  logic [3:0][DATA_WIDTH-1:0] lo_w;
  logic [3:0][DATA_WIDTH-1:0] hi_w;

  for (genvar k = 0; k < 4; k++) begin : g_sew
    localparam int unsigned W = 8 << k;
    for (genvar i = 0; i < DATA_WIDTH / W; i++) begin : g_lane
      logic [2*W-1:0] prod;
      vmul_lane #(
        .W(W)
      ) u_lane (
        .a_i       (op_a[i*W+:W]),
        .b_i       (op_b[i*W+:W]),
        .a_signed_i(a_signed),
        .b_signed_i(b_signed),
        .prod_o    (prod)
      );
      assign lo_w[k][i*W+:W] = prod[W-1:0];
      assign hi_w[k][i*W+:W] = prod[2*W-1:W];
    end
  end

  logic [DATA_WIDTH-1:0] lo_sel;
  logic [DATA_WIDTH-1:0] hi_sel;
  logic [DATA_WIDTH-1:0] res_vd;
  logic [DATA_WIDTH-1:0] res_hi;

  always_comb begin
    lo_sel = '0;
    hi_sel = '0;
    case (ev.sew)
      SEW_8:   begin lo_sel = lo_w[0]; hi_sel = hi_w[0]; end
      SEW_16:  begin lo_sel = lo_w[1]; hi_sel = hi_w[1]; end
      SEW_32:  begin lo_sel = lo_w[2]; hi_sel = hi_w[2]; end
      SEW_64:  begin lo_sel = lo_w[3]; hi_sel = hi_w[3]; end
      default: ;
    endcase

    res_vd = '0;
    res_hi = '0;
    case (ev.mul_op)
      MUL_OP_MUL: begin
        res_vd = lo_sel;
        res_hi = hi_sel;
      end
      MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU: begin
        res_vd = hi_sel;
        res_hi = lo_sel;
      end
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] vd_d, vd_q;
  logic [DATA_WIDTH-1:0] vd_high_d, vd_high_q;
  logic                  valid_d, valid_q;

  always_comb begin
    vd_d      = vd_q;
    vd_high_d = vd_high_q;
    valid_d   = vld;
    if (vld) begin
      vd_d      = res_vd;
      vd_high_d = res_hi;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vd_q      <= '0;
      vd_high_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      vd_q      <= vd_d;
      vd_high_q <= vd_high_d;
      valid_q   <= valid_d;
    end
  end

  assign vd        = vd_q;
  assign vd_high   = vd_high_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_vector_multiply_unit.sv
// Directed + random bench for vector_multiply_unit with a queue scoreboard of expected results.
module tb_vector_multiply_unit;
  import dragonfang_pkg::*;

`ifdef VMUL_INPUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  execution_vector_t execution_vector;
  logic              valid_in;
  logic [63:0]       vs2;
  logic [63:0]       vs1;
  logic [63:0]       vd;
  logic [63:0]       vd_high;
  logic              valid_out;

  vector_multiply_unit #(
    .DATA_WIDTH(64)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .execution_vector(execution_vector),
    .valid_in        (valid_in),
    .vs2             (vs2),
    .vs1             (vs1),
    .vd              (vd),
    .vd_high         (vd_high),
    .valid_out       (valid_out)
  );

  always #5 clock = ~clock;

  logic [127:0] exp_q[$];
  bit           vld_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [63:0]  held_vd = '0;
  logic [63:0]  held_hi = '0;

  // Golden model: returns {vd, vd_high}.
  function automatic logic [127:0] model(mul_op_t op, sew_t sew, logic [63:0] a, logic [63:0] b);
    int          s;
    logic [63:0] rvd;
    logic [63:0] rhi;
    s   = 8 << sew;
    rvd = '0;
    rhi = '0;
    for (int i = 0; i < 64 / s; i++) begin
      logic [127:0] ae, be, p, lo, hi, mask;
      mask = (128'd1 << s) - 128'd1;
      ae   = {64'd0, a >> (i * s)} & mask;
      be   = {64'd0, b >> (i * s)} & mask;
      if (op != MUL_OP_MULHU && ae[s-1]) ae = ae | ~mask;
      if ((op == MUL_OP_MUL || op == MUL_OP_MULH) && be[s-1]) be = be | ~mask;
      p  = ae * be;
      lo = p & mask;
      hi = (p >> s) & mask;
      if (op == MUL_OP_MUL) begin
        rvd = rvd | (lo[63:0] << (i * s));
        rhi = rhi | (hi[63:0] << (i * s));
      end else begin
        rvd = rvd | (hi[63:0] << (i * s));
        rhi = rhi | (lo[63:0] << (i * s));
      end
    end
    return {rvd, rhi};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic collect(input string tag);
    bit           v;
    logic [127:0] e;
    if (vld_q.size() >= Lat) begin
      v = vld_q.pop_front();
      chk({tag, " valid_out"}, {63'd0, valid_out}, {63'd0, v});
      if (v) begin
        if (exp_q.size() == 0) begin
          chk({tag, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
          e       = exp_q.pop_front();
          held_vd = e[127:64];
          held_hi = e[63:0];
          chk({tag, " vd"}, vd, held_vd);
          chk({tag, " vd_high"}, vd_high, held_hi);
        end
      end else begin
        chk({tag, " vd hold"}, vd, held_vd);
        chk({tag, " vd_high hold"}, vd_high, held_hi);
      end
    end
  endtask

  task automatic issue(input string tag, input bit v, input mul_op_t op, input sew_t sew,
                       input logic [63:0] a, input logic [63:0] b, input logic [127:0] e);
    execution_vector        = '0;
    execution_vector.mul_op = op;
    execution_vector.sew    = sew;
    valid_in                = v;
    vs2                     = a;
    vs1                     = b;
    vld_q.push_back(v);
    if (v) exp_q.push_back(e);
    @(posedge clock);
    #1;
    collect(tag);
  endtask

  task automatic issue_m(input string tag, input bit v, input mul_op_t op, input sew_t sew,
                         input logic [63:0] a, input logic [63:0] b);
    issue(tag, v, op, sew, a, b, model(op, sew, a, b));
  endtask

  initial begin
    execution_vector = '0;
    valid_in         = 1'b0;
    vs2              = '0;
    vs1              = '0;

    #2;
    chk("reset vd", vd, 64'd0);
    chk("reset vd_high", vd_high, 64'd0);
    chk("reset valid_out", {63'd0, valid_out}, 64'd0);
    #11 reset_n = 1'b1;

    issue("mul64", 1'b1, MUL_OP_MUL, SEW_64, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
          {64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFF});
    issue("mulh64", 1'b1, MUL_OP_MULH, SEW_64, 64'h8000_0000_0000_0000, 64'd2,
          {64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
    issue("mulhu64", 1'b1, MUL_OP_MULHU, SEW_64, 64'h8000_0000_0000_0000, 64'd2,
          {64'd1, 64'd0});
    issue("mul16", 1'b1, MUL_OP_MUL, SEW_16, 64'h0002_0003_0004_FFFF, 64'h0003_0003_0003_0002,
          {64'h0006_0009_000C_FFFE, 64'h0000_0000_0000_FFFF});
    issue("mulh8", 1'b1, MUL_OP_MULH, SEW_8, '1, '1, {64'd0, 64'h0101_0101_0101_0101});
    issue("mulhu8", 1'b1, MUL_OP_MULHU, SEW_8, '1, '1,
          {64'hFEFE_FEFE_FEFE_FEFE, 64'h0101_0101_0101_0101});
    issue("mulhsu8", 1'b1, MUL_OP_MULHSU, SEW_8, '1, '1,
          {64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101});
    issue("mulh32", 1'b1, MUL_OP_MULH, SEW_32, 64'h7FFF_FFFF_7FFF_FFFF, 64'h7FFF_FFFF_7FFF_FFFF,
          {64'h3FFF_FFFF_3FFF_FFFF, 64'h0000_0001_0000_0001});
    issue("mulovf64", 1'b1, MUL_OP_MUL, SEW_64, 64'h8000_0000_0000_0000, '1,
          {64'h8000_0000_0000_0000, 64'd0});
    issue_m("mulhsu32", 1'b1, MUL_OP_MULHSU, SEW_32, 64'h8000_0001_FFFF_FFFE,
            64'hFFFF_FFFF_0000_0003);
    issue_m("idle0", 1'b0, MUL_OP_MUL, SEW_8, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F);
    issue_m("idle1", 1'b0, MUL_OP_MULH, SEW_16, 64'hDEAD_BEEF_0BAD_F00D, 64'h1111_2222_3333_4444);
    issue_m("idle2", 1'b0, MUL_OP_MUL, SEW_64, '0, '0);

    for (int i = 0; i < 4; i++) begin
      issue_m("b2b", 1'b1, mul_op_t'($urandom_range(0, 3)), sew_t'($urandom_range(0, 3)),
              {$urandom, $urandom}, {$urandom, $urandom});
    end
    #2 reset_n = 1'b0;
    #1;
    chk("midreset vd", vd, 64'd0);
    chk("midreset vd_high", vd_high, 64'd0);
    chk("midreset valid_out", {63'd0, valid_out}, 64'd0);
    exp_q.delete();
    vld_q.delete();
    held_vd  = '0;
    held_hi  = '0;
    valid_in = 1'b0;
    @(posedge clock);
    #1;
    chk("inreset vd", vd, 64'd0);
    chk("inreset valid_out", {63'd0, valid_out}, 64'd0);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      issue_m("rand", ($urandom_range(0, 9) != 0), mul_op_t'($urandom_range(0, 3)),
              sew_t'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom});
    end
    for (int i = 0; i < Lat + 1; i++) begin
      issue_m("drain", 1'b0, MUL_OP_MUL, SEW_8, '0, '0);
    end
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
